// File: rtl/id_dispatch_if.sv
// Bundle between fetch, register file, execute FIFO and writeback for id_dispatch.
// The master side is the surrounding pipeline; the slave side is the dispatch stage.
interface id_dispatch_if #(
    parameter int DATA_W  = 16,
    parameter int REG_AW  = 4,
    parameter int OPC_W   = 5,
    parameter int INSTR_W = 32
);
    localparam int NREG  = 2 ** REG_AW;
    localparam int PKT_W = 2 * DATA_W + OPC_W + REG_AW;

    logic               instr_valid;
    logic               instr_ready;
    logic [INSTR_W-1:0] instruction;
    logic [REG_AW-1:0]  rs1_addr;
    logic [REG_AW-1:0]  rs2_addr;
    logic [REG_AW-1:0]  rd_addr;
    logic [DATA_W-1:0]  rs1_data;
    logic [DATA_W-1:0]  rs2_data;
    logic               out_valid;
    logic               out_ready;
    logic [PKT_W-1:0]   out_data;
    logic               wb_valid;
    logic [REG_AW-1:0]  wb_rd;
    logic               illegal_op;
    logic [NREG-1:0]    busy_vec;

    modport master (
        output instr_valid, instruction, rs1_data, rs2_data, out_ready, wb_valid, wb_rd,
        input  instr_ready, rs1_addr, rs2_addr, rd_addr, out_valid, out_data, illegal_op, busy_vec
    );

    modport slave (
        input  instr_valid, instruction, rs1_data, rs2_data, out_ready, wb_valid, wb_rd,
        output instr_ready, rs1_addr, rs2_addr, rd_addr, out_valid, out_data, illegal_op, busy_vec
    );
endinterface

// File: rtl/id_dispatch.sv
// Decode/dispatch stage: splits instructions, samples operands, queues packets in a 2-entry buffer.
// Optional RAW scoreboard enabled with `define ID_SCOREBOARD_EN.
`ifndef OP_MOV
`define OP_MOV            5'd0
`define OP_ADD            5'd1
`define OP_SUB            5'd2
`define OP_AND            5'd3
`define OP_OR             5'd4
`define OP_NOT            5'd5
`define OP_CMP            5'd6
`define OP_MULT           5'd7
`define OP_DIV            5'd8
`define OP_OB_CHECK       5'd9
`define OP_VELOCITY_GUARD 5'd10
`define OP_MOVE_LEFT      5'd11
`define OP_MOVE_RIGHT     5'd12
`define OP_STOP           5'd13
`define OP_CONTINUE       5'd14
`endif

module id_dispatch #(
    parameter int DATA_W  = 16,
    parameter int REG_AW  = 4,
    parameter int OPC_W   = 5,
    parameter int INSTR_W = 32
) (
    input logic          clk,
    input logic          reset,
    id_dispatch_if.slave bus
);
    localparam int NREG  = 2 ** REG_AW;
    localparam int PKT_W = 2 * DATA_W + OPC_W + REG_AW;
    localparam int LOW_W = INSTR_W - OPC_W - 3 * REG_AW;

    typedef enum logic [1:0] {CLS_R, CLS_C, CLS_ILL} op_class_t;

    logic [OPC_W-1:0]  opcode;
    logic [REG_AW-1:0] rd, rs1, rs2;
    op_class_t         cls;
    logic [PKT_W-1:0]  pkt;
    logic [PKT_W-1:0]  mem0, mem1;
    logic [1:0]        count;
    logic              pop, accept, push, hazard, illegal_q;
    logic              unused_low;

    assign opcode = bus.instruction[INSTR_W-1 -: OPC_W];
    assign rd     = bus.instruction[INSTR_W-OPC_W-1 -: REG_AW];
    assign rs1    = bus.instruction[INSTR_W-OPC_W-REG_AW-1 -: REG_AW];
    assign rs2    = bus.instruction[INSTR_W-OPC_W-2*REG_AW-1 -: REG_AW];
    assign unused_low = ^bus.instruction[LOW_W-1:0];

    assign bus.rd_addr  = rd;
    assign bus.rs1_addr = rs1;
    assign bus.rs2_addr = rs2;

    always_comb begin
        cls = CLS_ILL;
        case (opcode)
            `OP_MOV, `OP_ADD, `OP_SUB, `OP_AND, `OP_OR, `OP_NOT, `OP_CMP,
            `OP_MULT, `OP_DIV, `OP_OB_CHECK, `OP_VELOCITY_GUARD:   cls = CLS_R;
            `OP_MOVE_LEFT, `OP_MOVE_RIGHT, `OP_STOP, `OP_CONTINUE: cls = CLS_C;
            default:                                             cls = CLS_ILL;
        endcase
    end

    always_comb begin
        pkt = {{(2*DATA_W){1'b0}}, opcode, rd};
        if (cls == CLS_R) pkt = {bus.rs2_data, bus.rs1_data, opcode, rd};
    end

    assign pop             = (count != 2'd0) && bus.out_ready;
    assign bus.instr_ready = ((count < 2'd2) || pop) && !hazard;
    assign accept          = bus.instr_valid && bus.instr_ready;
    assign push            = accept && (cls != CLS_ILL);

    // mem0 is always the head; a pop that empties the buffer leaves mem0 alone
    // so out_data keeps its last value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count     <= '0;
            mem0      <= '0;
            mem1      <= '0;
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= accept && (cls == CLS_ILL);
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) mem0 <= pkt;
                    else               mem1 <= pkt;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    if (count == 2'd2) mem0 <= mem1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        mem0 <= pkt;
                    end else begin
                        mem0 <= mem1;
                        mem1 <= pkt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.out_valid  = (count != 2'd0);
    assign bus.out_data   = mem0;
    assign bus.illegal_op = illegal_q;

`ifdef ID_SCOREBOARD_EN
    logic [NREG-1:0] busy, wb_mask, eff_busy;

    // Writeback bypass: a register retiring this cycle no longer blocks issue.
    always_comb begin
        wb_mask = '0;
        if (bus.wb_valid) wb_mask[bus.wb_rd] = 1'b1;
        eff_busy = busy & ~wb_mask;
        hazard   = (cls == CLS_R) && (eff_busy[rs1] || eff_busy[rs2] || eff_busy[rd]);
    end

    // The later set overrides the clear when both hit the same register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy <= '0;
        end else begin
            busy <= eff_busy;
            if (accept && (cls == CLS_R)) busy[rd] <= 1'b1;
        end
    end

    assign bus.busy_vec = busy;
`else
    logic unused_wb;
    assign unused_wb    = ^{bus.wb_valid, bus.wb_rd};
    assign hazard       = 1'b0;
    assign bus.busy_vec = '0;
`endif
endmodule

// File: tb/tb_id_dispatch.sv
// Directed self-checking bench for id_dispatch; expectations follow ID_SCOREBOARD_EN.
module tb_id_dispatch;
    localparam int PKT_W = 41;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    id_dispatch_if #(.DATA_W(16), .REG_AW(4), .OPC_W(5), .INSTR_W(32)) bus ();

    id_dispatch #(.DATA_W(16), .REG_AW(4), .OPC_W(5), .INSTR_W(32)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [31:0] mk(input logic [4:0] op, input logic [3:0] rd,
                                       input logic [3:0] rs1, input logic [3:0] rs2);
        return {op, rd, rs1, rs2, 15'h0};
    endfunction

    task automatic idle_inputs;
        bus.instr_valid = 1'b0;
        bus.instruction = '0;
        bus.rs1_data    = '0;
        bus.rs2_data    = '0;
        bus.out_ready   = 1'b0;
        bus.wb_valid    = 1'b0;
        bus.wb_rd       = '0;
    endtask

    task automatic do_reset;
        @(negedge clk);
        idle_inputs();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        @(negedge clk);
        #1;
        checks += 5;
        if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        if (bus.out_data !== {PKT_W{1'b0}}) begin failures++; $display("FAIL reset_out_data got=%h exp=0", bus.out_data); end
        if (bus.illegal_op !== 1'b0) begin failures++; $display("FAIL reset_illegal got=%b exp=0", bus.illegal_op); end
        if (bus.busy_vec !== 16'h0) begin failures++; $display("FAIL reset_busy got=%h exp=0", bus.busy_vec); end
        if (bus.instr_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", bus.instr_ready); end
        reset = 1'b0;
    endtask

    task automatic test_mid_reset;
        logic [15:0] exp_busy;
`ifdef ID_SCOREBOARD_EN
        exp_busy = 16'h0006;
`else
        exp_busy = 16'h0000;
`endif
        do_reset();
        bus.instruction = mk(5'd0, 4'd1, 4'd8, 4'd9);
        bus.rs1_data = 16'h1111; bus.rs2_data = 16'h2222;
        bus.instr_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        bus.instruction = mk(5'd0, 4'd2, 4'd8, 4'd9);
        @(posedge clk); @(negedge clk);
        bus.instr_valid = 1'b0;
        #1;
        checks += 3;
        if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL full_out_valid got=%b exp=1", bus.out_valid); end
        if (bus.instr_ready !== 1'b0) begin failures++; $display("FAIL full_ready got=%b exp=0", bus.instr_ready); end
        if (bus.busy_vec !== exp_busy) begin failures++; $display("FAIL full_busy got=%h exp=%h", bus.busy_vec, exp_busy); end
        #2 reset = 1'b1;
        #1;
        checks += 3;
        if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL midrst_out_valid got=%b exp=0", bus.out_valid); end
        if (bus.out_data !== {PKT_W{1'b0}}) begin failures++; $display("FAIL midrst_out_data got=%h exp=0", bus.out_data); end
        if (bus.busy_vec !== 16'h0) begin failures++; $display("FAIL midrst_busy got=%h exp=0", bus.busy_vec); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (bus.instr_ready !== 1'b1) begin failures++; $display("FAIL midrst_ready got=%b exp=1", bus.instr_ready); end
    endtask

    task automatic test_add;
        logic [PKT_W-1:0] exp_pkt;
        logic [15:0]      exp_busy;
        exp_pkt = {16'h00FF, 16'h1234, 5'd1, 4'd3};
`ifdef ID_SCOREBOARD_EN
        exp_busy = 16'h0008;
`else
        exp_busy = 16'h0000;
`endif
        do_reset();
        bus.out_ready = 1'b1;
        bus.instruction = mk(5'd1, 4'd3, 4'd1, 4'd2);
        bus.rs1_data = 16'h1234; bus.rs2_data = 16'h00FF;
        bus.instr_valid = 1'b1;
        #1;
        checks += 4;
        if (bus.rs1_addr !== 4'd1) begin failures++; $display("FAIL add_rs1_addr got=%h exp=1", bus.rs1_addr); end
        if (bus.rs2_addr !== 4'd2) begin failures++; $display("FAIL add_rs2_addr got=%h exp=2", bus.rs2_addr); end
        if (bus.rd_addr !== 4'd3) begin failures++; $display("FAIL add_rd_addr got=%h exp=3", bus.rd_addr); end
        if (bus.instr_ready !== 1'b1) begin failures++; $display("FAIL add_ready got=%b exp=1", bus.instr_ready); end
        @(posedge clk); @(negedge clk);
        bus.instr_valid = 1'b0;
        #1;
        checks += 3;
        if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL add_out_valid got=%b exp=1", bus.out_valid); end
        if (bus.out_data !== exp_pkt) begin failures++; $display("FAIL add_out_data got=%h exp=%h", bus.out_data, exp_pkt); end
        if (bus.busy_vec !== exp_busy) begin failures++; $display("FAIL add_busy got=%h exp=%h", bus.busy_vec, exp_busy); end
        @(posedge clk); @(negedge clk);
        #1;
        checks += 2;
        if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL empty_out_valid got=%b exp=0", bus.out_valid); end
        if (bus.out_data !== exp_pkt) begin failures++; $display("FAIL empty_hold got=%h exp=%h", bus.out_data, exp_pkt); end
        bus.wb_valid = 1'b1; bus.wb_rd = 4'd3;
        @(posedge clk); @(negedge clk);
        bus.wb_valid = 1'b0;
        #1;
        checks++;
        if (bus.busy_vec !== 16'h0) begin failures++; $display("FAIL wb_clear_busy got=%h exp=0", bus.busy_vec); end
    endtask

    task automatic test_class_c;
        logic [PKT_W-1:0] exp_pkt;
        exp_pkt = {32'h0, 5'd13, 4'd5};
        do_reset();
        bus.out_ready = 1'b1;
        bus.instruction = mk(5'd13, 4'd5, 4'd6, 4'd7);
        bus.rs1_data = 16'hAAAA; bus.rs2_data = 16'h5555;
        bus.instr_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        bus.instr_valid = 1'b0;
        #1;
        checks += 3;
        if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL stop_out_valid got=%b exp=1", bus.out_valid); end
        if (bus.out_data !== exp_pkt) begin failures++; $display("FAIL stop_out_data got=%h exp=%h", bus.out_data, exp_pkt); end
        if (bus.busy_vec !== 16'h0) begin failures++; $display("FAIL stop_busy got=%h exp=0", bus.busy_vec); end
    endtask

    task automatic test_illegal;
        do_reset();
        bus.out_ready = 1'b1;
        bus.instruction = mk(5'd20, 4'd3, 4'd1, 4'd2);
        bus.instr_valid = 1'b1;
        #1;
        checks++;
        if (bus.instr_ready !== 1'b1) begin failures++; $display("FAIL ill_ready got=%b exp=1", bus.instr_ready); end
        @(posedge clk); @(negedge clk);
        bus.instr_valid = 1'b0;
        #1;
        checks += 3;
        if (bus.illegal_op !== 1'b1) begin failures++; $display("FAIL ill_pulse got=%b exp=1", bus.illegal_op); end
        if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL ill_out_valid got=%b exp=0", bus.out_valid); end
        if (bus.busy_vec !== 16'h0) begin failures++; $display("FAIL ill_busy got=%h exp=0", bus.busy_vec); end
        @(posedge clk); @(negedge clk);
        #1;
        checks++;
        if (bus.illegal_op !== 1'b0) begin failures++; $display("FAIL ill_pulse_end got=%b exp=0", bus.illegal_op); end
    endtask

    task automatic test_back_to_back;
        logic [PKT_W-1:0] pa, pb, pc;
        pa = {16'h2001, 16'h1001, 5'd0, 4'd1};
        pb = {16'h2002, 16'h1002, 5'd0, 4'd2};
        pc = {16'h2003, 16'h1003, 5'd0, 4'd3};
        do_reset();
        bus.instruction = mk(5'd0, 4'd1, 4'd8, 4'd9);
        bus.rs1_data = 16'h1001; bus.rs2_data = 16'h2001;
        bus.instr_valid = 1'b1;
        #1;
        checks++;
        if (bus.instr_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_a got=%b exp=1", bus.instr_ready); end
        @(posedge clk); @(negedge clk);
        bus.instruction = mk(5'd0, 4'd2, 4'd8, 4'd9);
        bus.rs1_data = 16'h1002; bus.rs2_data = 16'h2002;
        #1;
        checks++;
        if (bus.instr_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_b got=%b exp=1", bus.instr_ready); end
        @(posedge clk); @(negedge clk);
        bus.instruction = mk(5'd0, 4'd3, 4'd8, 4'd9);
        bus.rs1_data = 16'h1003; bus.rs2_data = 16'h2003;
        #1;
        checks += 2;
        if (bus.instr_ready !== 1'b0) begin failures++; $display("FAIL b2b_full_ready got=%b exp=0", bus.instr_ready); end
        if (bus.out_data !== pa) begin failures++; $display("FAIL b2b_head_a got=%h exp=%h", bus.out_data, pa); end
        @(posedge clk); @(negedge clk);
        #1;
        checks += 3;
        if (bus.instr_ready !== 1'b0) begin failures++; $display("FAIL b2b_still_full got=%b exp=0", bus.instr_ready); end
        if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL b2b_stable_valid got=%b exp=1", bus.out_valid); end
        if (bus.out_data !== pa) begin failures++; $display("FAIL b2b_stable_a got=%h exp=%h", bus.out_data, pa); end
        bus.out_ready = 1'b1;
        #1;
        checks++;
        if (bus.instr_ready !== 1'b1) begin failures++; $display("FAIL b2b_pop_ready got=%b exp=1", bus.instr_ready); end
        @(posedge clk); @(negedge clk);
        bus.instr_valid = 1'b0;
        #1;
        checks++;
        if (bus.out_data !== pb) begin failures++; $display("FAIL b2b_head_b got=%h exp=%h", bus.out_data, pb); end
        @(posedge clk); @(negedge clk);
        #1;
        checks++;
        if (bus.out_data !== pc) begin failures++; $display("FAIL b2b_head_c got=%h exp=%h", bus.out_data, pc); end
        @(posedge clk); @(negedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL b2b_drained got=%b exp=0", bus.out_valid); end
    endtask

    task automatic test_hazard;
        logic [PKT_W-1:0] exp_pkt;
        logic [15:0]      exp_busy;
        exp_pkt = {16'h0044, 16'h0033, 5'd2, 4'd4};
`ifdef ID_SCOREBOARD_EN
        exp_busy = 16'h0010;
`else
        exp_busy = 16'h0000;
`endif
        do_reset();
        bus.out_ready = 1'b1;
        bus.instruction = mk(5'd1, 4'd4, 4'd1, 4'd2);
        bus.rs1_data = 16'h0011; bus.rs2_data = 16'h0022;
        bus.instr_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        bus.instruction = mk(5'd2, 4'd4, 4'd4, 4'd6);
        bus.rs1_data = 16'h0033; bus.rs2_data = 16'h0044;
        #1;
`ifdef ID_SCOREBOARD_EN
        checks++;
        if (bus.instr_ready !== 1'b0) begin failures++; $display("FAIL raw_stall got=%b exp=0", bus.instr_ready); end
        @(posedge clk); @(negedge clk);
        #1;
        checks++;
        if (bus.instr_ready !== 1'b0) begin failures++; $display("FAIL raw_stall_hold got=%b exp=0", bus.instr_ready); end
        bus.wb_valid = 1'b1; bus.wb_rd = 4'd4;
        #1;
`endif
        checks++;
        if (bus.instr_ready !== 1'b1) begin failures++; $display("FAIL raw_release got=%b exp=1", bus.instr_ready); end
        @(posedge clk); @(negedge clk);
        bus.instr_valid = 1'b0;
        bus.wb_valid = 1'b0;
        #1;
        checks += 3;
        if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL raw_out_valid got=%b exp=1", bus.out_valid); end
        if (bus.out_data !== exp_pkt) begin failures++; $display("FAIL raw_out_data got=%h exp=%h", bus.out_data, exp_pkt); end
        if (bus.busy_vec !== exp_busy) begin failures++; $display("FAIL raw_set_wins got=%h exp=%h", bus.busy_vec, exp_busy); end
        bus.wb_valid = 1'b1; bus.wb_rd = 4'd7;
        @(posedge clk); @(negedge clk);
        bus.wb_valid = 1'b0;
        #1;
        checks++;
        if (bus.busy_vec !== exp_busy) begin failures++; $display("FAIL wb_noop got=%h exp=%h", bus.busy_vec, exp_busy); end
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_mid_reset();
        test_add();
        test_class_c();
        test_illegal();
        test_back_to_back();
        test_hazard();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
